// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared op/state types and op-decode helpers for the divider sign control.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } div_state_e;

  function automatic logic is_signed_op(div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_sign_ctrl_fixup.sv
// rtl/div_sign_ctrl_fixup.sv - result select and sign restore for quotient/remainder.
module div_fixup
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  div_op_e               op,
  input  logic                  sign_a,
  input  logic                  sign_b,
  input  logic [DATA_WIDTH-1:0] quot,
  input  logic [DATA_WIDTH-1:0] rem,
  output logic [DATA_WIDTH-1:0] result
);

  // Remainder takes the dividend's sign; quotient is negative when signs differ.
  always_comb begin
    result = quot;
    if (is_rem_op(op)) begin
      result = (is_signed_op(op) && sign_a) ? -rem : rem;
    end else if (is_signed_op(op) && (sign_a ^ sign_b)) begin
      result = -quot;
    end
  end

endmodule

// File: rtl/div_sign_ctrl.sv
// rtl/div_sign_ctrl.sv - signed/unsigned wrapper around an unsigned iterative divider.
// Optional DIVREM_REUSE_EN: reuse the last divider result for a repeated operand pair.
module div_sign_ctrl
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [DATA_WIDTH-1:0] req_a_i,
  input  logic [DATA_WIDTH-1:0] req_b_i,
  input  logic                  flush_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic [DATA_WIDTH-1:0] div_dividend_o,
  output logic [DATA_WIDTH-1:0] div_divisor_o,
  output logic                  div_enable_o,
  input  logic                  div_finished_i,
  input  logic [DATA_WIDTH-1:0] div_quot_i,
  input  logic [DATA_WIDTH-1:0] div_rem_i
);

  localparam logic [DATA_WIDTH-1:0] MIN_INT  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

  div_state_e            state_q, state_d;
  div_op_e               op_q;
  logic                  sign_a_q, sign_b_q;
  logic [DATA_WIDTH-1:0] mag_a_q, mag_b_q, resp_q;
  logic                  alive_q;

  div_op_e               req_op;
  logic                  req_signed, req_sign_a, req_sign_b;
  logic [DATA_WIDTH-1:0] req_mag_a, req_mag_b;
  logic                  accept, special, reuse_hit;
  logic [DATA_WIDTH-1:0] special_result;

  div_op_e               fix_op;
  logic                  fix_sign_a, fix_sign_b;
  logic [DATA_WIDTH-1:0] fix_quot, fix_rem, fix_result;

  assign req_op     = div_op_e'(req_op_i);
  assign req_signed = is_signed_op(req_op);
  assign req_sign_a = req_signed & req_a_i[DATA_WIDTH-1];
  assign req_sign_b = req_signed & req_b_i[DATA_WIDTH-1];
  assign req_mag_a  = req_sign_a ? -req_a_i : req_a_i;
  assign req_mag_b  = req_sign_b ? -req_b_i : req_b_i;

  // alive_q keeps ready low during and right out of reset.
  assign req_ready_o    = alive_q && (state_q == S_IDLE) && !flush_i;
  assign accept         = req_valid_i && req_ready_o;
  assign resp_valid_o   = (state_q == S_DONE);
  assign resp_data_o    = resp_q;
  assign div_enable_o   = (state_q == S_START);
  assign div_dividend_o = mag_a_q;
  assign div_divisor_o  = mag_b_q;

  always_comb begin
    special        = 1'b0;
    special_result = '0;
    if (req_b_i == '0) begin
      special        = 1'b1;
      special_result = is_rem_op(req_op) ? req_a_i : ALL_ONES;
    end else if (req_signed && req_a_i == MIN_INT && req_b_i == ALL_ONES) begin
      special        = 1'b1;
      special_result = is_rem_op(req_op) ? '0 : MIN_INT;
    end
  end

`ifdef DIVREM_REUSE_EN
  logic                  reuse_valid_q, reuse_signed_q, reuse_sign_a_q, reuse_sign_b_q;
  logic [DATA_WIDTH-1:0] reuse_mag_a_q, reuse_mag_b_q, reuse_quot_q, reuse_rem_q;

  assign reuse_hit = reuse_valid_q && (reuse_signed_q == req_signed) &&
                     (reuse_sign_a_q == req_sign_a) && (reuse_sign_b_q == req_sign_b) &&
                     (reuse_mag_a_q == req_mag_a) && (reuse_mag_b_q == req_mag_b);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reuse_valid_q  <= 1'b0;
      reuse_signed_q <= 1'b0;
      reuse_sign_a_q <= 1'b0;
      reuse_sign_b_q <= 1'b0;
      reuse_mag_a_q  <= '0;
      reuse_mag_b_q  <= '0;
      reuse_quot_q   <= '0;
      reuse_rem_q    <= '0;
    end else if (flush_i || state_q == S_START) begin
      reuse_valid_q <= 1'b0;
    end else if (state_q == S_WAIT && div_finished_i) begin
      reuse_valid_q  <= 1'b1;
      reuse_signed_q <= is_signed_op(op_q);
      reuse_sign_a_q <= sign_a_q;
      reuse_sign_b_q <= sign_b_q;
      reuse_mag_a_q  <= mag_a_q;
      reuse_mag_b_q  <= mag_b_q;
      reuse_quot_q   <= div_quot_i;
      reuse_rem_q    <= div_rem_i;
    end
  end
`else
  assign reuse_hit = 1'b0;
`endif

  // One fixup serves both the divider return (WAIT) and the reuse path (IDLE).
  always_comb begin
    fix_op     = op_q;
    fix_sign_a = sign_a_q;
    fix_sign_b = sign_b_q;
    fix_quot   = div_quot_i;
    fix_rem    = div_rem_i;
`ifdef DIVREM_REUSE_EN
    if (state_q == S_IDLE) begin
      fix_op     = req_op;
      fix_sign_a = req_sign_a;
      fix_sign_b = req_sign_b;
      fix_quot   = reuse_quot_q;
      fix_rem    = reuse_rem_q;
    end
`endif
  end

  div_fixup #(.DATA_WIDTH(DATA_WIDTH)) u_fixup (
    .op     (fix_op),
    .sign_a (fix_sign_a),
    .sign_b (fix_sign_b),
    .quot   (fix_quot),
    .rem    (fix_rem),
    .result (fix_result)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = (special || reuse_hit) ? S_DONE : S_START;
      S_START: state_d = flush_i ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (flush_i)             state_d = div_finished_i ? S_IDLE : S_DRAIN;
        else if (div_finished_i) state_d = S_DONE;
      end
      S_DONE:  if (flush_i || resp_ready_i) state_d = S_IDLE;
      S_DRAIN: if (div_finished_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      alive_q  <= 1'b0;
      op_q     <= OP_DIV;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      resp_q   <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if (accept) begin
        op_q     <= req_op;
        sign_a_q <= req_sign_a;
        sign_b_q <= req_sign_b;
        mag_a_q  <= req_mag_a;
        mag_b_q  <= req_mag_b;
      end
      if (accept && special)                                      resp_q <= special_result;
      else if (accept && reuse_hit)                               resp_q <= fix_result;
      else if (state_q == S_WAIT && div_finished_i && !flush_i)   resp_q <= fix_result;
    end
  end

endmodule

// File: tb/tb_div_sign_ctrl.sv
// tb/tb_div_sign_ctrl.sv - directed and random checks of div_sign_ctrl against a behavioural divider.
module tb_div_sign_ctrl;
  import div_pkg::*;

  localparam int DW        = 32;
  localparam int MODEL_LAT = 3;
`ifdef DIVREM_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, flush, resp_valid, resp_ready;
  logic [1:0]    req_op;
  logic [DW-1:0] req_a, req_b, resp_data;
  logic [DW-1:0] div_dividend, div_divisor, div_quot, div_rem;
  logic          div_enable, div_finished;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_sign_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .req_a_i        (req_a),
    .req_b_i        (req_b),
    .flush_i        (flush),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_data_o    (resp_data),
    .div_dividend_o (div_dividend),
    .div_divisor_o  (div_divisor),
    .div_enable_o   (div_enable),
    .div_finished_i (div_finished),
    .div_quot_i     (div_quot),
    .div_rem_i      (div_rem)
  );

  // Behavioural unsigned divider: finishes a fixed number of cycles after launch.
  logic          busy;
  int            cnt;
  logic [DW-1:0] mq, mr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; cnt <= 0; mq <= '0; mr <= '0;
    end else if (div_enable) begin
      busy <= 1'b1;
      cnt  <= MODEL_LAT;
      mq   <= (div_divisor == 0) ? '1 : div_dividend / div_divisor;
      mr   <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
    end else if (busy) begin
      if (cnt == 0) busy <= 1'b0;
      else          cnt  <= cnt - 1;
    end
  end
  assign div_finished = busy && (cnt == 0);
  assign div_quot     = mq;
  assign div_rem      = mr;

  int en_count = 0;
  always @(posedge clk) if (div_enable) en_count <= en_count + 1;

  bit watch14 = 1'b0, saw14 = 1'b0;
  always @(negedge clk) if (watch14 && resp_data == 32'd14) saw14 <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] golden(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
        return $signed(a) / $signed(b);
      end
      default: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
    endcase
  endfunction

  // Issue one request, wait for its response (consumed when resp_ready=1).
  task automatic run_op(input string tag, input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int exp_en);
    int n, lat, en0;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk({tag, "_ready"}, req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    en0 = en_count;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin @(negedge clk); lat++; end
    chk({tag, "_valid"}, resp_valid, 1);
    if (!resp_valid) return;
    chk({tag, "_data"}, resp_data, exp);
    if (exp_lat >= 0) chk({tag, "_lat"}, lat, exp_lat);
    if (exp_en >= 0)  chk({tag, "_en"}, en_count - en0, exp_en);
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    div_op_e rop;

    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_a = '0; req_b = '0;
    flush = 1'b0; resp_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_enable", div_enable, 0);
    chk("rst_dividend", div_dividend, 0);
    chk("rst_divisor", div_divisor, 0);
    rst_n = 1'b1;

    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, -1, 1);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, REUSE ? 1 : -1, REUSE ? 0 : 1);
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_by0", OP_REMU, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op("div_by0", OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("rem_by0", OP_REM, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 1, 0);
    run_op("div_ovf", OP_DIV, MIN_INT, 32'hFFFF_FFFF, MIN_INT, 1, 0);
    run_op("rem_ovf", OP_REM, MIN_INT, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run_op("div_min_2", OP_DIV, MIN_INT, 32'd2, 32'hC000_0000, -1, 1);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, -1, 1);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, -1, 1);

    // Flush while the divider is busy: its result must never surface.
    saw14 = 1'b0; watch14 = 1'b1;
    @(negedge clk);
    req_op = OP_DIVU; req_a = 32'd100; req_b = 32'd7; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_no_valid", resp_valid, 0);
    chk("flush_ready_drain", req_ready, 0);
    run_op("flush_next", OP_DIVU, 32'd9, 32'd3, 32'd3, -1, 1);
    @(negedge clk);
    watch14 = 1'b0;
    chk("flush_no14", saw14, 0);

    // Response backpressure.
    resp_ready = 1'b0;
    @(negedge clk);
    req_op = OP_DIVU; req_a = 32'd50; req_b = 32'd5; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 200) begin @(negedge clk); n++; end
    chk("bp_valid", resp_valid, 1);
    chk("bp_data", resp_data, 32'd10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_data", resp_data, 32'd10);
      chk("bp_hold_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", resp_valid, 0);
    chk("bp_release_ready", req_ready, 1);

    // Flush while holding a response drops it.
    resp_ready = 1'b0;
    @(negedge clk);
    req_op = OP_DIVU; req_a = 32'd1; req_b = 32'd0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    chk("done_flush_pre", resp_valid, 1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("done_flush_drop", resp_valid, 0);
    resp_ready = 1'b1;

    run_op("reuse_div", OP_DIV, 32'd100, 32'd7, 32'd14, -1, 1);
    run_op("reuse_rem", OP_REM, 32'd100, 32'd7, 32'd2, REUSE ? 1 : -1, REUSE ? 0 : 1);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    req_op = OP_DIVU; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", resp_valid, 0);
    chk("arst_enable", div_enable, 0);
    chk("arst_dividend", div_dividend, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op("arst_after", OP_DIVU, 32'd1000, 32'd3, 32'd333, -1, 1);

    for (int k = 0; k < 500; k++) begin
      rop = div_op_e'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       ra = MIN_INT;
        1:       ra = $urandom_range(0, 20);
        2:       ra = -$urandom_range(1, 20);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 9);
        3:       rb = -$urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      run_op("rand", rop, ra, rb, golden(rop, ra, rb), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
